// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle W-bit adder/subtractor, CHUNK bits per clock.
// A registered carry links the slices, so only a CHUNK-bit adder is built.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           operation request, accepted in IDLE or DONE
//   sub             0: x + y + cin, 1: x - y (cin ignored)
//   x, y, cin       operands, captured when start is accepted
//   busy            high while slices are being processed
//   done            one-cycle pulse, s/cout/zero valid
//   s               sum/difference; partial during RUN, held after done
//   cout            carry out of MSB (subtract: 1 = no borrow, x >= y)
//   zero            s == 0, registered together with done
module seq_chunk_adder #(
    parameter int W     = 24,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         zero
);

    localparam int N  = W / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (W < 1 || CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: W must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   s_q, s_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           zero_q, zero_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_sum;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        a_sl      = '0;
        b_sl      = '0;

        // Constant-index slice mux keeps every part-select static.
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*CHUNK +: CHUNK];
                b_sl = b_q[k*CHUNK +: CHUNK];
            end
        end

        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is x + ~y + 1: invert y, force carry-in.
                    state_d = RUN;
                    a_d     = x;
                    b_d     = y ^ {W{sub}};
                    carry_d = sub | cin;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    zero_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                    end
                end
                carry_d = slice_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = slice_sum[CHUNK];
                    zero_d  = (s_d == '0);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder.
// Four instances: (24,8), (24,24), (24,1), (8,4).
module tb_seq_chunk_adder;

    int   total = 0;
    int   bad   = 0;
    int   nfin  = 0;
    int   cyc   = 0;
    logic clk   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic        c;
        logic        sb;
        logic [23:0] es;
        logic        ec;
        logic        ez;
    } vec_t;

    vec_t d24 [8] = '{
        '{24'h00FFFF, 24'h000001, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b0},
        '{24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1},
        '{24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0},
        '{24'h000007, 24'h000005, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0},
        '{24'h000005, 24'h000005, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b1},
        '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1},
        '{24'h123456, 24'h654321, 1'b1, 1'b0, 24'h777778, 1'b0, 1'b0},
        '{24'h000000, 24'h000001, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0}
    };

    vec_t d8 [8] = '{
        '{24'h0000FF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1},
        '{24'h000005, 24'h000007, 1'b0, 1'b1, 24'h0000FE, 1'b0, 1'b0},
        '{24'h000007, 24'h000005, 1'b1, 1'b1, 24'h000002, 1'b1, 1'b0},
        '{24'h00000F, 24'h000001, 1'b1, 1'b0, 24'h000011, 1'b0, 1'b0},
        '{24'h000080, 24'h00007F, 1'b0, 1'b0, 24'h0000FF, 1'b0, 1'b0},
        '{24'h000000, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1},
        '{24'h0000AA, 24'h000055, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1},
        '{24'h000001, 24'h0000FF, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b0}
    };

    function automatic void chk(input int inst, input string nm,
                                input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst=%0d act=%0h req=%0h", nm, inst, act, req);
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int PW = (g == 3) ? 8 : 24;
        localparam int PC = (g == 0) ? 8 : (g == 1) ? 24 : (g == 2) ? 1 : 4;
        localparam int PN = PW / PC;

        logic          rst;
        logic          start;
        logic          sub;
        logic          cin;
        logic          busy;
        logic          done;
        logic          cout;
        logic          zero;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW-1:0] s;

        logic [PW-1:0] q_s[$];
        logic          q_c[$];
        logic          q_z[$];
        int            q_t[$];

        seq_chunk_adder #(.W(PW), .CHUNK(PC)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .sub   (sub),
            .x     (x),
            .y     (y),
            .cin   (cin),
            .busy  (busy),
            .done  (done),
            .s     (s),
            .cout  (cout),
            .zero  (zero)
        );

        function automatic logic [PW:0] model(input logic [PW-1:0] a,
                                              input logic [PW-1:0] bb,
                                              input logic c, input logic sb);
            logic [PW:0] r;
            if (sb) begin
                r[PW-1:0] = a - bb;
                r[PW]     = (a >= bb);
            end else begin
                r = {1'b0, a} + {1'b0, bb} + {{PW{1'b0}}, c};
            end
            return r;
        endfunction

        task automatic push(input logic [PW-1:0] es, input logic ec, input logic ez);
            q_s.push_back(es);
            q_c.push_back(ec);
            q_z.push_back(ez);
            q_t.push_back(cyc + 1);
        endtask

        // Called at a negedge; returns at the negedge where done is high.
        task automatic op(input logic [PW-1:0] xv, input logic [PW-1:0] yv,
                          input logic cv, input logic sv,
                          input logic [PW-1:0] es, input logic ec,
                          input logic ez, input bit ign);
            x     = xv;
            y     = yv;
            cin   = cv;
            sub   = sv;
            start = 1'b1;
            push(es, ec, ez);
            @(negedge clk);
            start = 1'b0;
            x     = ~xv;
            y     = ~yv;
            cin   = ~cv;
            sub   = ~sv;
            for (int k = 0; k < PN; k++) begin
                chk(g, "busy_run", 64'(busy), 64'd1);
                if (k == 0 && ign) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            chk(g, "busy_end", 64'(busy), 64'd0);
        endtask

        task automatic rop(input logic [PW-1:0] xv, input logic [PW-1:0] yv,
                           input logic cv, input logic sv, input bit ign);
            logic [PW:0] r;
            r = model(xv, yv, cv, sv);
            op(xv, yv, cv, sv, r[PW-1:0], r[PW], r[PW-1:0] == '0, ign);
        endtask

        initial begin
            vec_t        v;
            logic [PW:0] r;
            rst   = 1'b1;
            start = 1'b0;
            sub   = 1'b0;
            cin   = 1'b0;
            x     = '0;
            y     = '0;
            #2;
            chk(g, "rst_busy", 64'(busy), 64'd0);
            chk(g, "rst_done", 64'(done), 64'd0);
            chk(g, "rst_s", 64'(s), 64'd0);
            chk(g, "rst_cout", 64'(cout), 64'd0);
            chk(g, "rst_zero", 64'(zero), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 8; i++) begin
                v = (PW == 24) ? d24[i] : d8[i];
                op(PW'(v.x), PW'(v.y), v.c, v.sb, PW'(v.es), v.ec, v.ez, (i % 2) == 1);
                if (i % 4 == 3) @(negedge clk);
            end

            // start held high: one accept every PN+1 edges
            start = 1'b1;
            for (int i = 0; i < 4 * (PN + 1); i++) begin
                x   = PW'($urandom);
                y   = PW'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
                if (i % (PN + 1) == 0) begin
                    r = model(x, y, cin, sub);
                    push(r[PW-1:0], r[PW], r[PW-1:0] == '0);
                end
                @(negedge clk);
            end
            start = 1'b0;
            @(negedge clk);

            // reset during the second RUN cycle
            x     = PW'(24'h5A5A5A);
            y     = PW'(24'h000001);
            cin   = 1'b0;
            sub   = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (PN > 1) @(negedge clk);
            rst = 1'b1;
            #1;
            chk(g, "mid_rst_busy", 64'(busy), 64'd0);
            chk(g, "mid_rst_done", 64'(done), 64'd0);
            chk(g, "mid_rst_s", 64'(s), 64'd0);
            chk(g, "mid_rst_cout", 64'(cout), 64'd0);
            chk(g, "mid_rst_zero", 64'(zero), 64'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (PN + 3) @(negedge clk);
            rop(PW'(24'hFFFFFF), PW'(24'h000001), 1'b0, 1'b0, 1'b0);
            @(negedge clk);

            for (int i = 0; i < 1000; i++) begin
                rop(PW'($urandom), PW'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end

            repeat (PN + 3) @(negedge clk);
            chk(g, "drain", 64'(q_s.size()), 64'd0);
            nfin++;
        end

        logic [PW-1:0] es;
        logic          ec;
        logic          ez;
        int            et;

        always @(negedge clk) begin
            if (!rst && done) begin
                if (q_s.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done inst=%0d act=done req=none s=%0h", g, s);
                end else begin
                    es = q_s.pop_front();
                    ec = q_c.pop_front();
                    ez = q_z.pop_front();
                    et = q_t.pop_front();
                    chk(g, "s", 64'(s), 64'(es));
                    chk(g, "cout", 64'(cout), 64'(ec));
                    chk(g, "zero", 64'(zero), 64'(ez));
                    chk(g, "latency", 64'(cyc - et), 64'(PN));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 80000 && nfin < 4; i++) @(negedge clk);
        if (nfin < 4) begin
            total++;
            bad++;
            $display("FAIL timeout act=%0d req=4", nfin);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit half adder primitive in the FP datapath.
- Adds or subtracts two W-bit operands CHUNK bits per cycle, using a registered carry between slices.
- Used by mantissa add/sub and Taylor-series accumulation stages, where area matters more than latency.
- Start/done handshake; result held until the next operation is accepted.

Parameters:
- W, 24, operand/result width in bits (mantissa incl. hidden bit); W >= 1.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= W; W % CHUNK == 0 (elaboration error otherwise).
- N (localparam), W/CHUNK, number of slice cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled on rising clk edge
- sub  input  1  0: x+y+cin; 1: x-y (x + ~y + 1), cin ignored
- x  input  W  operand A, captured when start accepted
- y  input  W  operand B, captured when start accepted
- cin  input  1  carry-in for add mode, captured when start accepted
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse, result valid
- s  output  W  sum/difference, registered
- cout  output  1  carry out of MSB (sub: 1 = no borrow, x >= y)
- zero  output  1  s == 0, registered with done

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, s=0, cout=0, zero=0, slice counter=0, internal operand/carry registers=0. Reset mid-operation aborts; no done is produced.
- States:
  - IDLE: start=1 -> RUN. Capture x, y^{W{sub}}, carry=sub?1:cin. Clear s. Counter=0. busy=1 from the next cycle.
  - RUN: each edge adds slice k of the captured operands plus carry. Writes s[k*CHUNK +: CHUNK] and updates carry; counter++.
    - On slice N-1: cout=final carry, zero=(full s==0), state -> DONE, busy=0, done=1.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back; done and new busy do not overlap).
    - Otherwise -> IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge EN (N cycles after the accepting edge). Throughput is one op per N+1 cycles.
- start while busy=1 is ignored; the operands in flight are unaffected by changes to x/y/sub/cin.
- s, cout and zero hold their values from done until the next accepted start. s reads partial values during RUN and is only valid once done has asserted.
- Arithmetic is modulo 2^W; overflow is reported only through cout. No signed-overflow flag.
- N=1 (CHUNK=W): RUN lasts a single cycle, done comes 1 cycle after start.

Test Plan:
- W=24, CHUNK=8, add: x=0x00FFFF, y=0x000001, cin=0, start pulse -> busy high 3 cycles, done after 3 cycles; s=0x010000, cout=0, zero=0.
- Add with wrap: x=0xFFFFFF, y=0x000000, cin=1 -> s=0x000000, cout=1, zero=1. Carry propagates across all 3 slices.
- Sub: x=0x000005, y=0x000007, sub=1 -> s=0xFFFFFE, cout=0 (borrow). Second op x=7, y=5 -> s=0x000002, cout=1.
- Back-to-back: start held high continuously with changing operands -> done every 4th cycle, each result matches the operands captured at its accepting edge. start pulses during busy are ignored.
- Reset mid-op: assert rst during the 2nd RUN cycle -> all outputs 0 at once, no done. After release, a new start gives a correct result.
- Parameter sweep: (W,CHUNK) = (24,24), (24,1), (8,4), 1000 random ops each vs a reference model -> s/cout/zero exact. Latency is N cycles.
